quadrilatero_xif_issuer: RTL

CPU-side initiator for the coprocessor XIF issue and commit channels of the quadrilatero matrix unit. It buffers offload requests (instruction word plus two source operands) in a small FIFO. It presents them one at a time on the issue channel and captures the coprocessor's accept/reject response. It then closes each transaction with a commit (or kill) beat. It serves as the integration-side driver for the matrix unit in standalone SoC bring-up and in the block-level environment.

---
 rtl/quadrilatero_xif_issuer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/quadrilatero_xif_issuer.sv
// quadrilatero_xif_issuer
// CPU-side XIF initiator for the quadrilatero matrix unit. It buffers offload
// requests in a small FIFO, presents them one at a time on the issue channel,
// and closes each transaction with a single commit (or kill) beat.
// Optional feature macro: QUADRILATERO_ISSUE_TIMEOUT_EN enables an issue-ready
// wait limit that drops the head instruction after TIMEOUT_CYCLES cycles.
module quadrilatero_xif_issuer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_instr_i,
  input  logic [31:0]           req_rs1_i,
  input  logic [31:0]           req_rs2_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [31:0]           issue_instr_o,
  output logic [63:0]           issue_rs_o,
  output logic [X_ID_WIDTH-1:0] issue_id_o,
  input  logic                  issue_accept_i,
  output logic                  commit_valid_o,
  output logic [X_ID_WIDTH-1:0] commit_id_o,
  output logic                  commit_kill_o,
  output logic                  busy_o,
  output logic [15:0]           accepted_cnt_o,
  output logic [15:0]           rejected_cnt_o,
  output logic                  timeout_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs2;
    logic [31:0] rs1;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  state_e                state_q;
  state_e                state_d;
  logic                  accept_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [X_ID_WIDTH-1:0] commit_id_q;
  logic [15:0]           acc_cnt_q;
  logic [15:0]           rej_cnt_q;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  handshake;
  logic                  drop;
  logic                  in_issue;
  entry_t                head;

  assign full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign push          = req_valid_i & ~full;
  assign head          = mem_q[rd_ptr_q];
  assign in_issue      = (state_q == ISSUE);
  assign issue_valid_o = in_issue & ~drop;
  assign handshake     = issue_valid_o & issue_ready_i;
  assign pop           = handshake | drop;

`ifdef QUADRILATERO_ISSUE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  // The drop cycle follows TIMEOUT_CYCLES cycles of issue_valid without a handshake.
  assign drop = in_issue & (wait_q == WAIT_W'(TIMEOUT_CYCLES));

  // Count cycles spent waiting in ISSUE; clear on handshake, drop, or leaving ISSUE.
  always_comb begin
    wait_d = '0;
    if (in_issue && !pop) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign timeout_o = drop;

  // Next FIFO occupancy; a push and a pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Payload storage; entries are only read once written, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_instr_i, req_rs2_i, req_rs1_i};
    end
  end

  // FIFO pointers and occupancy (pointers wrap naturally at a power-of-two depth).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Next-state logic; looking at next occupancy gives push-to-issue in one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_d != '0) state_d = ISSUE;
      ISSUE:   if (pop) state_d = COMMIT;
      COMMIT:  state_d = (count_d != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction bookkeeping; counters move on the edge into COMMIT so they already
  // include the transaction whose commit beat is being shown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accept_q    <= 1'b0;
      id_q        <= '0;
      commit_id_q <= '0;
      acc_cnt_q   <= '0;
      rej_cnt_q   <= '0;
    end else if (handshake) begin
      accept_q    <= issue_accept_i;
      commit_id_q <= id_q;
      id_q        <= id_q + X_ID_WIDTH'(1);
      if (issue_accept_i) begin
        if (acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
      end else begin
        if (rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
      end
    end else if (drop) begin
      accept_q    <= 1'b0;
      commit_id_q <= id_q;
      id_q        <= id_q + X_ID_WIDTH'(1);
    end
  end

  assign req_ready_o    = ~full;
  assign issue_instr_o  = issue_valid_o ? head.instr : 32'd0;
  assign issue_rs_o     = issue_valid_o ? {head.rs2, head.rs1} : 64'd0;
  assign issue_id_o     = id_q;
  assign commit_valid_o = (state_q == COMMIT);
  assign commit_id_o    = commit_id_q;
  assign commit_kill_o  = commit_valid_o & ~accept_q;
  assign busy_o         = (count_q != '0) | (state_q != IDLE);
  assign accepted_cnt_o = acc_cnt_q;
  assign rejected_cnt_o = rej_cnt_q;

endmodule
